// File: rtl/aes_round_key_sequencer.sv
// Round-key sequencer: captures an expanded AES key schedule on start and serves one
// 128-bit round key per valid/ready handshake, in forward or reverse round order.
module aes_round_key_sequencer #(
  parameter  int unsigned NR       = 10,
  parameter  int unsigned NB       = 4,
  localparam int unsigned KEY_BITS = 128 * NB * (NR + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [0:KEY_BITS-1] full_keys_i,
  input  logic                start_i,
  input  logic                decrypt_i,
  input  logic                abort_i,
  output logic [127:0]        rk_data_o,
  output logic [3:0]          rk_round_o,
  output logic                rk_valid_o,
  output logic                rk_last_o,
  input  logic                rk_ready_i,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned      RK_W      = 128;
  localparam int unsigned      IDX_W     = 4;
  localparam int unsigned      USED_BITS = RK_W * (NR + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NR);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dec_q, dec_d;
  logic             capture_c;
  logic [RK_W-1:0]  keys_q [0:NR];
  logic [RK_W-1:0]  rk_data_q, rk_data_d;
  logic [IDX_W-1:0] rk_round_q, rk_round_d;
  logic             rk_last_q, rk_last_d;
  logic             valid_q;
  logic             done_q, done_d;
  logic             unused_tail;

  // Bits beyond the Nr+1 round keys carry nothing this block consumes.
  assign unused_tail = ^full_keys_i[USED_BITS:KEY_BITS-1];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dec_d     = dec_q;
    capture_c = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = STREAM;
          capture_c = 1'b1;
          dec_d     = decrypt_i;
          idx_d     = decrypt_i ? LAST_IDX : '0;
        end
      end
      STREAM: begin
        // rk_valid is always high here, so rk_ready alone marks a transfer
        if (abort_i) begin
          state_d = IDLE;
        end else if (rk_ready_i) begin
          if (rk_last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = dec_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rk_data_d  = '0;
    rk_round_d = '0;
    rk_last_d  = 1'b0;
    if (state_d == STREAM) begin
      rk_round_d = idx_d;
      rk_last_d  = dec_d ? (idx_d == '0) : (idx_d == LAST_IDX);
      // On the capture cycle the stored schedule is not loaded yet; read the port.
      if (capture_c) begin
        rk_data_d = decrypt_i ? full_keys_i[RK_W*NR +: RK_W] : full_keys_i[0 +: RK_W];
      end else begin
        rk_data_d = keys_q[idx_d];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      dec_q      <= 1'b0;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      rk_last_q  <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dec_q      <= dec_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
      rk_last_q  <= rk_last_d;
      valid_q    <= (state_d == STREAM);
      done_q     <= done_d;
    end
  end

  // Schedule storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (capture_c) begin
      for (int unsigned r = 0; r <= NR; r++) begin
        keys_q[r] <= full_keys_i[RK_W*r +: RK_W];
      end
    end
  end

  assign rk_data_o  = rk_data_q;
  assign rk_round_o = rk_round_q;
  assign rk_valid_o = valid_q;
  assign rk_last_o  = rk_last_q;
  assign busy_o     = valid_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Bench for aes_round_key_sequencer: AES-128 and AES-256 instances, a list-based
// reference model checked every cycle, plus literal FIPS-197 round-key checks.
module tb_aes_round_key_sequencer;

  localparam int unsigned NB  = 4;
  localparam int unsigned NRA = 10;
  localparam int unsigned NRB = 14;
  localparam int unsigned KBA = 128 * NB * (NRA + 1);
  localparam int unsigned KBB = 128 * NB * (NRB + 1);

  typedef struct packed {
    logic [31:0]  cyc;
    logic [3:0]   round;
    logic         last;
    logic [127:0] data;
  } xfer_t;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic decrypt  = 1'b0;
  logic abort    = 1'b0;
  logic rk_ready = 1'b1;
  logic start_a  = 1'b0;
  logic start_b  = 1'b0;
  logic [0:KBA-1] fk_a;
  logic [0:KBB-1] fk_b;

  logic [127:0] data_a, data_b;
  logic [3:0]   round_a, round_b;
  logic         valid_a, valid_b, last_a, last_b, busy_a, busy_b, done_a, done_b;

  int          checks = 0;
  int          bad    = 0;
  int unsigned cyc    = 0;
  xfer_t       log_a[$];
  xfer_t       log_b[$];
  int          done_cnt [2] = '{0, 0};
  int unsigned done_cyc [2] = '{0, 0};

  bit           m_known = 1'b0;
  bit           m_act  [2] = '{1'b0, 1'b0};
  bit           m_dec  [2] = '{1'b0, 1'b0};
  bit           m_done [2] = '{1'b0, 1'b0};
  int unsigned  m_pos  [2] = '{0, 0};
  logic [127:0] m_cap  [2][0:15];

  logic [127:0] sched_a [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  logic [127:0] sched_b [0:14] = '{
    128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4,
    128'h9ba354118e6925afa51a8b5f2067fcde, 128'ha8b09c1a93d194cdbe49846eb75d5b9a,
    128'hd59aecb85bf3c917fee94248de8ebe96, 128'hb5a9328a2678a647983122292f6c79b3,
    128'h812c81addadf48ba24360af2fab8b464, 128'h98c5bfc9bebd198e268c3ba709e04214,
    128'h68007bacb2df331696e939e46c518d80, 128'hc814e20476a9fb8a5025c02d59c58239,
    128'hde1369676ccc5a71fa2563959674ee15, 128'h5886ca5d2e2f31d77e0af1fa27cf73c3,
    128'h749c47ab18501ddae2757e4f7401905a, 128'hcafaaae3e4d59b349adf6acebd10190d,
    128'hfe4890d1e6188d0b046df344706c631e};

  always #5 clk = ~clk;

  aes_round_key_sequencer #(.NR(NRA), .NB(NB)) u_aes128 (
    .clk_i(clk), .reset_i(reset), .full_keys_i(fk_a), .start_i(start_a),
    .decrypt_i(decrypt), .abort_i(abort), .rk_data_o(data_a), .rk_round_o(round_a),
    .rk_valid_o(valid_a), .rk_last_o(last_a), .rk_ready_i(rk_ready),
    .busy_o(busy_a), .done_o(done_a));

  aes_round_key_sequencer #(.NR(NRB), .NB(NB)) u_aes256 (
    .clk_i(clk), .reset_i(reset), .full_keys_i(fk_b), .start_i(start_b),
    .decrypt_i(decrypt), .abort_i(abort), .rk_data_o(data_b), .rk_round_o(round_b),
    .rk_valid_o(valid_b), .rk_last_o(last_b), .rk_ready_i(rk_ready),
    .busy_o(busy_b), .done_o(done_b));

  // Reference model: a sequence is the list 0..Nr (or reversed), walked one entry per transfer.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      logic [135:0] act;
      logic [135:0] exp;
      int unsigned  nr;
      int unsigned  rnd;
      logic         st;
      nr  = (d == 0) ? NRA : NRB;
      act = (d == 0) ? {valid_a, busy_a, done_a, last_a, round_a, data_a}
                     : {valid_b, busy_b, done_b, last_b, round_b, data_b};
      rnd = m_dec[d] ? nr - m_pos[d] : m_pos[d];
      exp = '0;
      if (m_act[d]) exp = {1'b1, 1'b1, 1'b0, (m_pos[d] == nr), 4'(rnd), m_cap[d][rnd]};
      exp[133] = m_done[d];
      if (m_known) begin
        checks++;
        if (act !== exp) begin
          bad++;
          $display("FAIL cycle_check dut%0d cyc=%0d got v%b b%b d%b l%b r%0d %h expected v%b b%b d%b l%b r%0d %h",
                   d, cyc, act[135], act[134], act[133], act[132], act[131:128], act[127:0],
                   exp[135], exp[134], exp[133], exp[132], exp[131:128], exp[127:0]);
        end
        if (act[135] && rk_ready && !abort && !reset) begin
          if (d == 0) log_a.push_back('{cyc, act[131:128], act[132], act[127:0]});
          else        log_b.push_back('{cyc, act[131:128], act[132], act[127:0]});
        end
        if (act[133]) begin
          done_cnt[d]++;
          done_cyc[d] = cyc;
        end
      end
      st = (d == 0) ? start_a : start_b;
      m_done[d] = 1'b0;
      if (reset) begin
        m_act[d] = 1'b0;
      end else if (!m_act[d]) begin
        if (st) begin
          m_act[d] = 1'b1;
          m_dec[d] = decrypt;
          m_pos[d] = 0;
          if (d == 0) for (int unsigned r = 0; r <= NRA; r++) m_cap[0][r] = fk_a[128*r +: 128];
          else        for (int unsigned r = 0; r <= NRB; r++) m_cap[1][r] = fk_b[128*r +: 128];
        end
      end else if (abort) begin
        m_act[d] = 1'b0;
      end else if (rk_ready) begin
        if (m_pos[d] == nr) begin
          m_act[d]  = 1'b0;
          m_done[d] = 1'b1;
        end else begin
          m_pos[d]++;
        end
      end
    end
    if (reset) m_known = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [135:0] a, input logic [135:0] e);
    checks++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, a, e);
    end
  endtask

  task automatic load_a();
    fk_a = '0;
    for (int unsigned r = 0; r <= NRA; r++) fk_a[128*r +: 128] = sched_a[r];
  endtask

  task automatic start_seq(input int d, input bit dec);
    decrypt = dec;
    if (d == 0) start_a = 1'b1;
    else        start_b = 1'b1;
    tick(1);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget, input bit rand_ready, input bit flip_keys);
    int n = 0;
    while (((d == 0) ? busy_a : busy_b) && n < budget) begin
      if (rand_ready) rk_ready = 1'($urandom_range(0, 1));
      if (flip_keys && n == 3) fk_a = ~fk_a;
      tick(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      bad++;
      $display("FAIL wait_idle dut%0d still busy after %0d cycles", d, n);
    end
    rk_ready = 1'b1;
  endtask

  initial begin
    int dc;
    int n;
    bit ok;
    load_a();
    fk_b = '0;
    for (int unsigned r = 0; r <= NRB; r++) fk_b[128*r +: 128] = sched_b[r];
    tick(3);
    reset = 1'b0;
    chk("reset_a", {valid_a, busy_a, done_a, last_a, round_a, data_a}, '0);
    chk("reset_b", {valid_b, busy_b, done_b, last_b, round_b, data_b}, '0);

    // Forward AES-128, consumer always ready
    log_a.delete(); dc = done_cnt[0];
    start_seq(0, 1'b0); wait_idle(0, 40, 1'b0, 1'b0); tick(1);
    chk("t1_count", 136'(log_a.size()), 136'(11));
    if (log_a.size() == 11) begin
      chk("t1_r0", {log_a[0].round, log_a[0].data}, {4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c});
      chk("t1_r1", {log_a[1].round, log_a[1].data}, {4'd1, 128'ha0fafe1788542cb123a339392a6c7605});
      chk("t1_r10", {log_a[10].last, log_a[10].round, log_a[10].data},
          {1'b1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
      chk("t1_done_gap", 136'(done_cyc[0] - log_a[10].cyc), 136'(1));
    end
    chk("t1_done_cnt", 136'(done_cnt[0] - dc), 136'(1));

    // Reverse AES-128
    log_a.delete();
    start_seq(0, 1'b1); wait_idle(0, 40, 1'b0, 1'b0); tick(1);
    chk("t2_count", 136'(log_a.size()), 136'(11));
    if (log_a.size() == 11) begin
      chk("t2_first", {log_a[0].last, log_a[0].round, log_a[0].data},
          {1'b0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
      chk("t2_last", {log_a[10].last, log_a[10].round, log_a[10].data},
          {1'b1, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c});
    end

    // Random stalls, upstream schedule corrupted mid-stream
    log_a.delete();
    start_seq(0, 1'b0); wait_idle(0, 300, 1'b1, 1'b1); tick(1);
    load_a();
    chk("t3_count", 136'(log_a.size()), 136'(11));
    ok = (log_a.size() == 11);
    for (int i = 0; i < log_a.size(); i++)
      if (log_a[i].round != 4'(i) || log_a[i].data != sched_a[i]) ok = 1'b0;
    chk("t3_order_captured", 136'(ok), 136'(1));

    // Forward AES-256
    log_b.delete();
    start_seq(1, 1'b0); wait_idle(1, 40, 1'b0, 1'b0); tick(1);
    chk("t4_count", 136'(log_b.size()), 136'(15));
    if (log_b.size() == 15) begin
      chk("t4_r0", log_b[0].data, 136'(128'h603deb1015ca71be2b73aef0857d7781));
      chk("t4_r14", {log_b[14].last, log_b[14].round, log_b[14].data},
          {1'b1, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e});
    end

    // Abort on the round-4 transfer
    log_a.delete(); dc = done_cnt[0];
    start_seq(0, 1'b0);
    n = 0;
    while (!(valid_a && round_a == 4'd4) && n < 20) begin
      tick(1);
      n++;
    end
    chk("t5_reach_r4", 136'(n < 20), 136'(1));
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("t5_after_abort", {valid_a, busy_a, done_a}, '0);
    tick(3);
    chk("t5_no_done", 136'(done_cnt[0] - dc), '0);
    chk("t5_xfers", 136'(log_a.size()), 136'(4));
    log_a.delete();
    start_seq(0, 1'b0); wait_idle(0, 40, 1'b0, 1'b0); tick(1);
    if (log_a.size() > 0)
      chk("t5_restart", {log_a[0].round, log_a[0].data}, {4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c});
    chk("t5_restart_count", 136'(log_a.size()), 136'(11));

    // start held through done, then reset mid-stream
    decrypt = 1'b0;
    start_a = 1'b1;
    tick(1);
    n = 0;
    while (!done_a && n < 40) begin
      tick(1);
      n++;
    end
    chk("t6_done_seen", 136'(done_a), 136'(1));
    chk("t6_gap_cycle", {valid_a, busy_a}, '0);
    tick(1);
    chk("t6_restart", {valid_a, busy_a, round_a}, {1'b1, 1'b1, 4'd0});
    start_a = 1'b0;
    tick(3);
    reset = 1'b1; tick(1);
    chk("t6_reset", {valid_a, busy_a, done_a, last_a, round_a, data_a}, '0);
    reset = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout total=%0d bad=%0d", checks, bad);
    $fatal(1);
  end

endmodule
